// File: rtl/dht11_leitor_if.sv
// Bus/handshake bundle between the DHT11 reader and its surroundings:
// pad level in, pad pull-down enable out, measurement words and status.
interface dht11_leitor_if;
  logic        medir;
  logic        dht_in;
  logic        dht_out_en;
  logic [15:0] temperatura;
  logic [15:0] umidade;
  logic        pronto;
  logic        erro_checksum;
  logic        erro_timeout;
  logic        ocupado;
  logic [3:0]  db_estado;

  // master: the side that requests measurements and models the pad
  modport master (
    output medir, dht_in,
    input  dht_out_en, temperatura, umidade, pronto,
           erro_checksum, erro_timeout, ocupado, db_estado
  );

  // slave: the reader itself
  modport slave (
    input  medir, dht_in,
    output dht_out_en, temperatura, umidade, pronto,
           erro_checksum, erro_timeout, ocupado, db_estado
  );
endinterface

// File: rtl/dht11_leitor.sv
// DHT11/DHT22 single-wire reader: start pulse, response check, 40-bit
// pulse-width decode, checksum verify, registered measurement words.
module dht11_leitor #(
  parameter int START_CYCLES   = 900000,
  parameter int THRESH_CYCLES  = 2500,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int CW             = 20
) (
  input  logic           clock,
  input  logic           reset,
  dht11_leitor_if.slave  bus
);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    START_LOW   = 4'd1,
    ESPERA_RESP = 4'd2,
    RESP_LOW    = 4'd3,
    RESP_HIGH   = 4'd4,
    BIT_LOW     = 4'd5,
    BIT_HIGH    = 4'd6,
    CHECA       = 4'd7,
    ERRO        = 4'd8
  } estado_t;

  localparam logic [CW-1:0] START_M1 = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] TO_M1    = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] THRESH   = CW'(THRESH_CYCLES);

  estado_t       estado;
  logic          s1, s2, s_prev;
  logic [CW-1:0] cnt;
  logic [39:0]   sh;
  logic [5:0]    nbits;
  logic          out_en_r, pronto_r, err_ck_r, err_to_r;
  logic [15:0]   temp_r, umid_r;
  logic          subida, descida, tmo, bit_val;
  logic [7:0]    soma;

  assign subida  = s2 & ~s_prev;
  assign descida = ~s2 & s_prev;
  assign tmo     = (cnt == TO_M1);
  // cnt misses the edge-detect cycle, so the true high width is cnt+1;
  // width > THRESH therefore becomes cnt >= THRESH.
  assign bit_val = (cnt >= THRESH);
  assign soma    = sh[39:32] + sh[31:24] + sh[23:16] + sh[15:8];

  // 2-FF synchronizer plus previous-value flop for edge detection; idle bus is high
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s1     <= bus.dht_in;
      s2     <= s1;
      s_prev <= s2;
    end
  end

  // Main FSM: all outputs registered; counter cleared on every state change
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= INICIAL;
      cnt      <= '0;
      sh       <= '0;
      nbits    <= '0;
      out_en_r <= 1'b0;
      pronto_r <= 1'b0;
      err_ck_r <= 1'b0;
      err_to_r <= 1'b0;
      temp_r   <= '0;
      umid_r   <= '0;
    end else begin
      pronto_r <= 1'b0;
      case (estado)
        INICIAL: begin
          out_en_r <= 1'b0;
          cnt      <= '0;
          if (bus.medir) begin
            estado   <= START_LOW;
            out_en_r <= 1'b1;
            err_ck_r <= 1'b0;
            err_to_r <= 1'b0;
            sh       <= '0;
            nbits    <= '0;
          end
        end
        START_LOW: begin
          if (cnt == START_M1) begin
            estado   <= ESPERA_RESP;
            out_en_r <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ESPERA_RESP: begin
          if (descida)  begin estado <= RESP_LOW; cnt <= '0; end
          else if (tmo) begin estado <= ERRO; err_to_r <= 1'b1; cnt <= '0; end
          else          cnt <= cnt + 1'b1;
        end
        RESP_LOW: begin
          if (subida)   begin estado <= RESP_HIGH; cnt <= '0; end
          else if (tmo) begin estado <= ERRO; err_to_r <= 1'b1; cnt <= '0; end
          else          cnt <= cnt + 1'b1;
        end
        RESP_HIGH: begin
          if (descida)  begin estado <= BIT_LOW; cnt <= '0; end
          else if (tmo) begin estado <= ERRO; err_to_r <= 1'b1; cnt <= '0; end
          else          cnt <= cnt + 1'b1;
        end
        BIT_LOW: begin
          if (subida)   begin estado <= BIT_HIGH; cnt <= '0; end
          else if (tmo) begin estado <= ERRO; err_to_r <= 1'b1; cnt <= '0; end
          else          cnt <= cnt + 1'b1;
        end
        BIT_HIGH: begin
          if (descida) begin
            sh     <= {sh[38:0], bit_val};
            nbits  <= nbits + 1'b1;
            cnt    <= '0;
            estado <= (nbits == 6'd39) ? CHECA : BIT_LOW;
          end else if (tmo) begin
            estado   <= ERRO;
            err_to_r <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECA: begin
          if (soma == sh[7:0]) begin
            umid_r   <= sh[39:24];
            temp_r   <= sh[23:8];
            pronto_r <= 1'b1;
          end else begin
            err_ck_r <= 1'b1;
          end
          estado <= INICIAL;
          cnt    <= '0;
        end
        ERRO: begin
          out_en_r <= 1'b0;
          estado   <= INICIAL;
          cnt      <= '0;
        end
        default: begin
          out_en_r <= 1'b0;
          estado   <= INICIAL;
          cnt      <= '0;
        end
      endcase
    end
  end

  assign bus.dht_out_en    = out_en_r;
  assign bus.temperatura   = temp_r;
  assign bus.umidade       = umid_r;
  assign bus.pronto        = pronto_r;
  assign bus.erro_checksum = err_ck_r;
  assign bus.erro_timeout  = err_to_r;
  assign bus.ocupado       = (estado != INICIAL);
  assign bus.db_estado     = estado;

endmodule

// File: tb/tb_dht11_leitor.sv
// Bench for dht11_leitor: behavioural sensor, frame/checksum model,
// directed scenario sequence with randomized frame contents.
module tb_dht11_leitor;
  localparam int ST = 100, TH = 50, TO = 200;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic sens  = 1'b1;
  always #5 clock = ~clock;

  dht11_leitor_if bus ();
  assign bus.dht_in = bus.dht_out_en ? 1'b0 : sens;

  dht11_leitor #(.START_CYCLES(ST), .THRESH_CYCLES(TH), .TIMEOUT_CYCLES(TO), .CW(20))
    dut (.clock(clock), .reset(reset), .bus(bus));

  int n_chk = 0, n_err = 0;
  int pr_cnt = 0, en_cnt = 0;
  logic [15:0] pr_t = '0, pr_h = '0;
  logic [15:0] exp_t = '0, exp_h = '0;

  // observe pronto pulses (with the words seen in that same cycle) and pull-down cycles
  always @(negedge clock) begin
    if (bus.pronto) begin
      pr_cnt++;
      pr_t = bus.temperatura;
      pr_h = bus.umidade;
    end
    if (bus.dht_out_en) en_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_ok(input logic [39:0] f);
    int s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return (s % 256) == int'(f[7:0]);
  endfunction

  function automatic logic [39:0] mk_frame(input logic [7:0] a, b, c, d);
    int s;
    s = a + b + c + d;
    return {a, b, c, d, 8'(s)};
  endfunction

  task automatic measure;
    @(negedge clock) bus.medir = 1'b1;
    @(negedge clock) bus.medir = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_temp"}, 40'(bus.temperatura), 40'(0));
    check({tag, "_umid"}, 40'(bus.umidade), 40'(0));
    check({tag, "_en"},   40'(bus.dht_out_en), 40'(0));
    check({tag, "_ocup"}, 40'(bus.ocupado), 40'(0));
    check({tag, "_est"},  40'(bus.db_estado), 40'(0));
    check({tag, "_pr"},   40'(bus.pronto), 40'(0));
  endtask

  // Sensor: waits for host release, answers, then sends 40 bits; decoded
  // value is derived from the high widths actually sent (width > TH -> 1).
  task automatic sensor(input logic [39:0] f, input int hi0, input int hi1,
                        input logic noise, input int abort_at, output logic [39:0] dec);
    int w, h;
    dec = '0;
    w = 0;
    while (bus.dht_out_en && w < 1000) begin @(negedge clock); w++; end
    check("start_release", 40'(w < 1000), 40'(1));
    repeat (20) @(negedge clock);
    sens = 1'b0; repeat (80) @(negedge clock);
    sens = 1'b1; repeat (80) @(negedge clock);
    for (int i = 0; i < 40; i++) begin
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        check_zero("abort");
        check("abort_ck", 40'(bus.erro_checksum), 40'(0));
        check("abort_to", 40'(bus.erro_timeout), 40'(0));
        return;
      end
      if (noise) bus.medir = (i >= 10 && i <= 20) ? 1'(i % 2) : 1'b0;
      sens = 1'b0; repeat (50) @(negedge clock);
      h = f[39-i] ? hi1 : hi0;
      dec[39-i] = (h > TH);
      sens = 1'b1; repeat (h) @(negedge clock);
    end
    bus.medir = 1'b0;
    sens = 1'b0; repeat (50) @(negedge clock);
    sens = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    while (bus.db_estado != 4'd0 && w < 3000) begin @(negedge clock); w++; end
    check({tag, "_idle"}, 40'(w < 3000), 40'(1));
  endtask

  task automatic expect_frame(input string tag, input logic [39:0] dec, input int pr0);
    logic ok;
    ok = frame_ok(dec);
    if (ok) begin
      exp_h = dec[39:24];
      exp_t = dec[23:8];
    end
    repeat (3) @(negedge clock);
    check({tag, "_pronto_n"}, 40'(pr_cnt - pr0), ok ? 40'(1) : 40'(0));
    if (ok) begin
      check({tag, "_pr_temp"}, 40'(pr_t), 40'(exp_t));
      check({tag, "_pr_umid"}, 40'(pr_h), 40'(exp_h));
    end
    check({tag, "_temp"}, 40'(bus.temperatura), 40'(exp_t));
    check({tag, "_umid"}, 40'(bus.umidade), 40'(exp_h));
    check({tag, "_eck"},  40'(bus.erro_checksum), ok ? 40'(0) : 40'(1));
    check({tag, "_eto"},  40'(bus.erro_timeout), 40'(0));
    check({tag, "_est"},  40'(bus.db_estado), 40'(0));
  endtask

  task automatic run_frame(input string tag, input logic [39:0] f, input int hi0, input int hi1,
                           input logic noise);
    logic [39:0] dec;
    int pr0;
    pr0 = pr_cnt;
    measure;
    sensor(f, hi0, hi1, noise, 99, dec);
    wait_idle(tag);
    expect_frame(tag, dec, pr0);
  endtask

  initial begin
    logic [39:0] dec, f;
    int t, e0, pr0;
    bus.medir = 1'b0;

    // reset held then released
    repeat (3) @(negedge clock);
    check_zero("rst_hold");
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_zero("rst_rel");
    check("rst_eck", 40'(bus.erro_checksum), 40'(0));
    check("rst_eto", 40'(bus.erro_timeout), 40'(0));

    // known frame: start pulse width and decode
    e0 = en_cnt;
    pr0 = pr_cnt;
    measure;
    check("start_en", 40'(bus.dht_out_en), 40'(1));
    check("start_est", 40'(bus.db_estado), 40'(1));
    sensor(40'h3C0019055A, 30, 70, 1'b0, 99, dec);
    wait_idle("f1");
    check("start_len", 40'(en_cnt - e0), 40'(ST));
    expect_frame("f1", dec, pr0);
    check("f1_umid_k", 40'(bus.umidade), 40'(16'h3C00));
    check("f1_temp_k", 40'(bus.temperatura), 40'(16'h1905));

    // same frame, bad checksum: outputs retained
    run_frame("f2", 40'h3C0019055B, 30, 70, 1'b0);
    check("f2_temp_k", 40'(bus.temperatura), 40'(16'h1905));

    // sensor silent: timeout exactly TO cycles after entering ESPERA_RESP
    measure;
    t = 0;
    while (bus.db_estado != 4'd2 && t < 1000) begin @(negedge clock); t++; end
    check("to_reach2", 40'(t < 1000), 40'(1));
    t = 0;
    while (!bus.erro_timeout && t < 1000) begin @(negedge clock); t++; end
    check("to_cycles", 40'(t), 40'(TO));
    @(negedge clock);
    check("to_est", 40'(bus.db_estado), 40'(0));
    check("to_en", 40'(bus.dht_out_en), 40'(0));
    check("to_eck", 40'(bus.erro_checksum), 40'(0));
    repeat (30) @(negedge clock);
    check("to_sticky", 40'(bus.erro_timeout), 40'(1));
    check("to_keep_t", 40'(bus.temperatura), 40'(16'h1905));
    pr0 = pr_cnt;
    measure;
    check("to_clear", 40'(bus.erro_timeout), 40'(0));
    f = mk_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    sensor(f, 30, 70, 1'b0, 99, dec);
    wait_idle("f3");
    expect_frame("f3", dec, pr0);

    // randomized valid frames
    for (int k = 0; k < 3; k++) begin
      f = mk_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      run_frame($sformatf("rnd%0d", k), f, 30, 70, 1'b0);
    end

    // threshold boundary: 51 -> 1, 50 -> 0, valid checksum
    f = mk_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    run_frame("bnd_ok", f, 50, 51, 1'b0);

    // alternating 51/50 highs: decode 0xAA.. and fail the checksum
    run_frame("bnd_alt", 40'hAAAAAAAAAA, 50, 51, 1'b0);

    // medir pulses mid-frame are ignored
    f = mk_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    run_frame("busy", f, 30, 70, 1'b1);
    repeat (10) @(negedge clock);
    check("busy_norestart", 40'(bus.db_estado), 40'(0));

    // async reset mid-frame at bit 25
    measure;
    sensor(f, 30, 70, 1'b0, 25, dec);
    @(negedge clock);
    sens = 1'b1;
    reset = 1'b1;
    exp_t = '0;
    exp_h = '0;
    repeat (5) @(negedge clock);
    check_zero("post_abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
